// File: rtl/conv_x_stream_tx.sv
// conv_x_stream_tx: buffers X signed samples from a host write port and streams them in
// address order over valid/ready. Defining CONV_X_STREAM_TX_LOOP_EN adds loop_en for back-to-back frames.
module conv_x_stream_tx #(
  parameter int X     = 128,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [$clog2(X)-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     x_data,
  output logic                 x_valid,
  input  logic                 x_ready
`ifdef CONV_X_STREAM_TX_LOOP_EN
  ,
  input  logic                 loop_en
`endif
);
  localparam int AW = $clog2(X);
  localparam int CW = $clog2(X + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(X - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(X - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rd_done_q, rd_done_d;
  logic [CW-1:0]    send_cnt_q, send_cnt_d;
  logic             done_q, done_d;
  logic             ram_v_q;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic             out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [WIDTH-1:0] mem [X];

  logic          loop_w, wr_fire, start_ok, pop, last_pop, restart, room, issue_next, rd_issue;
  logic [AW-1:0] rd_idx;

`ifdef CONV_X_STREAM_TX_LOOP_EN
  assign loop_w = loop_en;
`else
  assign loop_w = 1'b0;
`endif

  assign wr_fire  = (state_q == S_IDLE) && wr_en;
  assign start_ok = (state_q == S_IDLE) && start;
  assign pop      = out_v_q && x_ready;
  assign last_pop = pop && (send_cnt_q == LAST_CNT);
  assign restart  = last_pop && loop_w;

  // A read may issue only if its data is guaranteed a free slot (output or skid) when it lands.
  assign room = ({1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, ram_v_q}) <= (2'd1 + {1'b0, pop});
  assign issue_next = ((state_q == S_FILL) || (state_q == S_SEND)) && !rd_done_q && room;
  assign rd_issue   = start_ok || restart || issue_next;
  assign rd_idx     = (start_ok || restart) ? '0 : rd_addr_q;

  assign busy    = (state_q == S_FILL) || (state_q == S_SEND);
  assign done    = done_q;
  assign x_valid = out_v_q;
  assign x_data  = out_q;

  // NOTE: the sample buffer is deliberately left out of reset so it maps onto block RAM
  // and a reset mid-frame keeps the loaded samples.
  always_ff @(posedge clk) begin
    if (wr_fire && (int'(wr_addr) < X)) mem[wr_addr] <= wr_data;
    if (rd_issue) ram_q <= (wr_fire && (wr_addr == rd_idx)) ? wr_data : mem[rd_idx];
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      rd_done_q  <= 1'b0;
      send_cnt_q <= '0;
      done_q     <= 1'b0;
      ram_v_q    <= 1'b0;
      out_q      <= '0;
      out_v_q    <= 1'b0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_done_q  <= rd_done_d;
      send_cnt_q <= send_cnt_d;
      done_q     <= done_d;
      ram_v_q    <= rd_issue;
      out_q      <= out_d;
      out_v_q    <= out_v_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_done_d  = rd_done_q;
    send_cnt_d = pop ? send_cnt_q + 1'b1 : send_cnt_q;
    done_d     = last_pop;

    if (issue_next) begin
      if (rd_addr_q == LAST_ADDR) rd_done_d = 1'b1;
      else                        rd_addr_d = rd_addr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FILL;
          rd_addr_d  = AW'(1);
          rd_done_d  = 1'b0;
          send_cnt_d = '0;
        end
      end
      S_FILL: state_d = S_SEND;
      S_SEND: begin
        if (last_pop) begin
          if (loop_w) begin
            state_d    = S_FILL;
            rd_addr_d  = AW'(1);
            rd_done_d  = 1'b0;
            send_cnt_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register refills from skid first, then from the RAM read; the skid absorbs a
  // returning read only while the output register is stalled.
  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = ram_v_q;
        if (ram_v_q) skid_d = ram_q;
      end else if (ram_v_q) begin
        out_d   = ram_q;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (ram_v_q) begin
      skid_d   = ram_q;
      skid_v_d = 1'b1;
    end
  end

endmodule

// File: doc/conv_x_stream_tx.md
Name: conv_x_stream_tx

Overview:
- Transmit side of the x-sample valid/ready stream consumed by the conv_* convolution blocks.
- A host loads X signed samples into an internal buffer through a simple write port, then pulses start.
- The block streams the samples in address order 0..X-1 on x_data/x_valid/x_ready, honouring backpressure at full throughput.
- Used in the generated top level and on FPGA to feed one input vector per frame into a conv_* instance.

Parameters:
- X, 128, number of samples per frame (buffer depth); power of two not required, X >= 2.
- WIDTH, 16, sample width in bits (signed two's complement).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  buffer write strobe; honoured only when busy=0
- wr_addr  input  $clog2(X)  buffer write address
- wr_data  input  WIDTH  buffer write data
- start  input  1  one-cycle request to transmit one frame; honoured only when busy=0
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  single-cycle pulse after the final sample handshake
- x_data  output  WIDTH  signed sample to consumer
- x_valid  output  1  x_data holds a valid sample
- x_ready  input  1  consumer accepts the sample this cycle

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: busy=0, done=0, x_valid=0, x_data=0, all internal counters=0, state=IDLE. Buffer contents are not reset.
- Handshake: a transfer occurs on a rising edge where x_valid=1 and x_ready=1.
- While x_valid=1 and x_ready=0, x_data and x_valid hold unchanged.
- x_valid never depends combinationally on x_ready.
- Buffer: synchronous-read RAM of X x WIDTH with 1-cycle read latency. A write occurs when wr_en=1 and state=IDLE.
- Output stage: an output register plus one prefetch (skid) register, so that one sample per cycle is sustained while x_ready=1 and no sample is dropped or duplicated under arbitrary x_ready patterns.
- State IDLE: x_valid=0, busy=0. start=1 -> state FILL, read address=0, send count=0. If start and wr_en arrive in the same cycle, the write is performed and the start is accepted.
- State FILL: the read is in flight. Next cycle -> SEND; x_valid rises exactly 2 cycles after the start cycle, with x_data = buffer[0].
- State SEND: the read address advances whenever the prefetch path has room, and stops issuing after address X-1.
- Send count increments on each transfer. On the transfer that sends sample X-1: state -> DONE, x_valid=0 next cycle.
- State DONE: done=1 for exactly one cycle, busy=0 in the same cycle. Next cycle -> IDLE.
- busy=1 in FILL and SEND.
- start, wr_en, wr_addr and wr_data are ignored in FILL, SEND and DONE.
- Latency with x_ready held at 1: start at cycle t; samples transfer at cycles t+2 .. t+X+1; done=1 at cycle t+X+2.
- Counter widths: the address counter is $clog2(X) bits. The send count is $clog2(X+1) bits so that X is representable; no wrap-around occurs within a frame.
- Reset asserted mid-frame: next cycle x_valid=0, busy=0, state=IDLE. The partial frame is abandoned; buffer contents are preserved, so a fresh start re-sends from sample 0.
- The block performs no arithmetic on data; samples pass through bit-exact, sign preserved.

Optional Feature:
- Macro: CONV_X_STREAM_TX_LOOP_EN.
- When defined: an extra input port loop_en (1 bit) is present. With loop_en=1, the final transfer of a frame goes directly to FILL for the next frame (address 0) instead of DONE, busy stays 1, and done is pulsed for one cycle per completed frame. Clearing loop_en ends streaming after the current frame completes normally. The inter-frame gap is at most 2 cycles with x_ready=1.
- When undefined: there is no loop_en port, and behaviour is the single-frame-per-start flow above.

Test Plan:
- Reset then idle: x_valid=0, busy=0, done=0, x_data=0 for 10 cycles; start held 0.
- Load buffer[i]=i-64 for i=0..127, x_ready=1, start at cycle t: x_data = -64..63 on cycles t+2..t+129, done=1 only at t+130, exactly 128 transfers.
- Same load with x_ready toggling 1,0,0,1 repeating: 128 transfers in order -64..63 with no drops or duplicates; x_data is stable on every stalled cycle.
- wr_en to address 5 with data 0x7FFF and a second start, both during SEND: the streamed value at index 5 remains -59 (the value loaded before this frame), and the extra start creates no additional frame.
- Reset asserted on the 40th transfer cycle: x_valid=0 next cycle. A new start then streams from -64 again with buffer contents intact.
- With CONV_X_STREAM_TX_LOOP_EN defined, loop_en=1 for 3 frames then 0: 384 transfers, 3 done pulses, busy stays 1 throughout, and it returns to IDLE after the 3rd frame.
